// File: rtl/booth_mul_seq.sv
// Iterative radix-2 Booth signed multiplier: one add/sub/no-op step per RUN cycle, 2N-bit product.
// Optional macro BOOTH_EARLY_TERM_EN: leave RUN early once the remaining multiplier bits make every later step a no-op.
module booth_mul_seq #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  // state  | meaning
  // S_IDLE | waiting for start; product holds the last result
  // S_RUN  | one Booth step per cycle, r_cnt steps remaining
  // S_DONE | one-cycle done pulse, product valid
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int CW = $clog2(N + 1);

  state_t          r_state, w_state_nxt;
  logic [N-1:0]    r_m;
  logic [N:0]      r_a;
  logic [N-1:0]    r_q;
  logic            r_qm1;
  logic [CW-1:0]   r_cnt;
  logic [2*N-1:0]  r_product;

  logic            w_add, w_sub;
  logic [N:0]      w_m_ext, w_operand, w_sum, w_a_nxt;
  logic [N-1:0]    w_q_nxt;
  logic            w_last;
  logic            w_early;
  logic [2*N-1:0]  w_early_prod;

  // A is carried one bit wider than M so A +/- M cannot overflow before the shift.
  always_comb begin
    w_add     = ~r_q[0] & r_qm1;
    w_sub     = r_q[0] & ~r_qm1;
    w_m_ext   = {r_m[N-1], r_m};
    w_operand = '0;
    if (w_sub)      w_operand = ~w_m_ext;
    else if (w_add) w_operand = w_m_ext;
    w_sum     = r_a + w_operand + {{N{1'b0}}, w_sub};
    w_a_nxt   = {w_sum[N], w_sum[N:1]};
    w_q_nxt   = {w_sum[0], r_q[N-1:1]};
    w_last    = (r_cnt == CW'(1));
  end

`ifdef BOOTH_EARLY_TERM_EN
  logic [N-1:0]           w_mask;
  logic signed [2*N-1:0]  w_shifted;

  // After any shift A fits in N bits, so dropping the guard bit is safe here.
  always_comb begin
    w_mask       = ~({N{1'b1}} << r_cnt);
    w_early      = (((r_q ^ {N{r_qm1}}) & w_mask) == '0);
    w_shifted    = $signed({r_a[N-1:0], r_q}) >>> r_cnt;
    w_early_prod = w_shifted;
  end
`else
  assign w_early      = 1'b0;
  assign w_early_prod = '0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_early || w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m       <= '0;
      r_a       <= '0;
      r_q       <= '0;
      r_qm1     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_m   <= multiplicand;
            r_a   <= '0;
            r_q   <= multiplier;
            r_qm1 <= 1'b0;
            r_cnt <= CW'(N);
          end
        end
        S_RUN: begin
          if (w_early) begin
            r_product <= w_early_prod;
            r_cnt     <= '0;
          end else begin
            r_a   <= w_a_nxt;
            r_q   <= w_q_nxt;
            r_qm1 <= r_q[0];
            r_cnt <= r_cnt - CW'(1);
            if (w_last) r_product <= {w_a_nxt[N-1:0], w_q_nxt};
          end
        end
        default: ;
      endcase
    end
  end

  assign busy    = (r_state == S_RUN);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed bench for booth_mul_seq (N=8) with a scoreboard of expected products.
module tb_booth_mul_seq;

  localparam int N = 8;
`ifdef BOOTH_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [N-1:0]   multiplicand;
  logic [N-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;

  int total = 0;
  int bad   = 0;
  logic [2*N-1:0] sb[$];

  booth_mul_seq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .multiplicand(multiplicand), .multiplier(multiplier),
    .busy(busy), .done(done), .product(product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*N-1:0] mul_ref(input logic [N-1:0] m, input logic [N-1:0] q);
    int e;
    e = int'($signed(m)) * int'($signed(q));
    return e[2*N-1:0];
  endfunction

  // Expected RUN length: full N, or with early exit the first step j where
  // all unprocessed bits q[N-1:j] equal the previous bit (0 before bit 0).
  function automatic int run_len(input logic [N-1:0] q);
    logic p;
    logic ok;
    if (!EARLY) return N;
    for (int j = 0; j < N; j++) begin
      p  = (j == 0) ? 1'b0 : q[j-1];
      ok = 1'b1;
      for (int k = j; k < N; k++) if (q[k] != p) ok = 1'b0;
      if (ok) return j + 1;
    end
    return N;
  endfunction

  task automatic pop_exp(output logic [2*N-1:0] e);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
      e = '0;
    end else e = sb.pop_front();
  endtask

  task automatic do_op(input string tag, input logic [N-1:0] m, input logic [N-1:0] q);
    int nbusy;
    int cyc;
    logic [2*N-1:0] e;
    @(negedge clk);
    start = 1'b1; multiplicand = m; multiplier = q;
    sb.push_back(mul_ref(m, q));
    @(negedge clk);
    start = 1'b0; multiplicand = ~m; multiplier = ~q;
    nbusy = 0; cyc = 0;
    while (!done && cyc < 40) begin
      if (busy) nbusy++;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(run_len(q)));
    pop_exp(e);
    chk({tag, "_product"}, 32'(product), 32'(e));
    @(negedge clk);
    chk({tag, "_done_single"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [2*N-1:0] e;
    int dones;
    int last_done;
    int cyc;
    rst_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_product", 32'(product), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("m7_qm3", 8'd7, 8'hFD);
    chk("m7_qm3_const", 32'(product), 32'h0000FFEB);
    do_op("m128_q128", 8'h80, 8'h80);
    chk("m128_q128_const", 32'(product), 32'h00004000);
    do_op("m55_q0", 8'h55, 8'h00);
    chk("m55_q0_const", 32'(product), 32'h00000000);
    do_op("m7f_q81", 8'h7F, 8'h81);
    do_op("m80_q7f", 8'h80, 8'h7F);
    do_op("mff_qff", 8'hFF, 8'hFF);

    // start pulsed again during RUN is ignored
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd5; multiplier = 8'd6;
    sb.push_back(mul_ref(8'd5, 8'd6));
    @(negedge clk);
    start = 1'b0; multiplicand = '0; multiplier = '0;
    @(negedge clk);
    start = 1'b1; multiplicand = 8'h7F; multiplier = 8'h81;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        dones++;
        pop_exp(e);
        chk("ignore_start_product", 32'(product), 32'(e));
        chk("ignore_start_const", 32'(product), 32'h0000001E);
      end
      @(negedge clk);
    end
    chk("ignore_start_done_count", 32'(dones), 32'd1);

    // reset in RUN cycle 4
    @(negedge clk);
    start = 1'b1; multiplicand = 8'd3; multiplier = 8'd3;
    sb.push_back(mul_ref(8'd3, 8'd3));
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_product", 32'(product), 32'd0);
    pop_exp(e);
    @(negedge clk);
    rst_n = 1'b1;
    do_op("after_rst_m3_q3", 8'd3, 8'd3);
    chk("after_rst_const", 32'(product), 32'h00000009);

    // start held high: back-to-back operations
    @(negedge clk);
    start = 1'b1;
    last_done = -1;
    for (int k = 0; k < 4; k++) begin
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      sb.push_back(mul_ref(multiplicand, multiplier));
      cyc = 0;
      while (!busy && cyc < 10) begin @(negedge clk); cyc++; end
      chk("b2b_accept", 32'(busy), 32'd1);
      multiplicand = 8'($urandom);
      multiplier   = 8'($urandom);
      cyc = 0;
      while (!done && cyc < 40) begin @(negedge clk); cyc++; end
      chk("b2b_done_seen", 32'(done), 32'd1);
      pop_exp(e);
      chk("b2b_product", 32'(product), 32'(e));
`ifndef BOOTH_EARLY_TERM_EN
      if (last_done >= 0) chk("b2b_period", 32'($time / 10 - last_done), 32'(N + 2));
`endif
      last_done = int'($time / 10);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
